uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
Receive-side buffer that sits directly downstream of the UART receiver. It watches the receiver's data-ready flag, issues a one-cycle chip-enable/read strobe on the UART data bus, and captures the received byte plus its error flag. It stores the entries in a first-word-fall-through FIFO that the consumer drains with a valid/ready handshake. It also raises an idle-timeout flag for packet framing.

Parameters:
DEPTH, 16, FIFO entries; must be a power of two and at least 2
AW, 4, log2(DEPTH)
TIMEOUT, 1024, clk cycles without a new byte before rx_idle asserts while data is buffered; must be at least 2

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  asynchronous active-low reset
uart_data  input  8  UART receive data bus; valid during the cycle after uart_rd is asserted
uart_rdc  input  1  receiver data-complete; high while an unread byte waits in the UART
uart_error  input  1  receiver framing/parity error for the waiting byte
uart_ce  output  1  UART chip enable; asserted only together with uart_rd
uart_rd  output  1  UART read strobe, one cycle per byte
out_data  output  8  FIFO head byte
out_err  output  1  error flag stored with the head byte
out_valid  output  1  FIFO not empty
out_ready  input  1  consumer accepts the head entry
fifo_count  output  AW+1  number of stored entries, 0..DEPTH
fifo_full  output  1  fifo_count == DEPTH
fifo_empty  output  1  fifo_count == 0
rx_idle  output  1  idle timeout reached with data buffered

Behaviour:
- Reset (rst=0, asynchronous): FSM to IDLE; pointers, count and timeout counter to 0. Outputs after reset: uart_ce=0, uart_rd=0, out_valid=0, fifo_empty=1, fifo_full=0, fifo_count=0, rx_idle=0, out_data=0, out_err=0.
- out_data and out_err are forced to 0 whenever the FIFO is empty.
- Reset mid-read drops any in-flight byte. The strobe goes low immediately.
- FSM states and transitions:
  - IDLE: go to RD when uart_rdc=1 and fifo_full=0. When full, stay in IDLE and issue no strobe. This is backpressure; the UART holds or overruns by its own rules.
  - RD: uart_ce=1 and uart_rd=1 for exactly this one cycle. Always go to CAP.
  - CAP: on the closing edge, write {uart_error, uart_data} into the FIFO at the write pointer. Go to WAIT if uart_rdc=1, else to IDLE.
  - WAIT: hold until uart_rdc=0, then go to IDLE. This prevents a second read of the same byte.
- Latency:
  - Minimum 3 cycles from uart_rdc rising to out_valid=1 on an empty FIFO.
  - At most one byte is read per 3 cycles.
- Pop: occurs on a rising edge where out_valid=1 and out_ready=1. The next entry appears on out_data in the following cycle (FWFT).
- Simultaneous push (CAP) and pop: fifo_count unchanged; both pointers advance.
- Pointers are AW bits and wrap modulo DEPTH. Count saturation is impossible because IDLE checks full before RD.
- out_ready while empty is ignored; no underflow occurs.
- Full condition: a push can still complete into the last free slot, since the full check happens only at IDLE→RD.
- Timeout counter (width sized for TIMEOUT):
  - Cleared on every push.
  - Cleared whenever the FIFO is empty.
  - Otherwise increments each cycle and saturates at TIMEOUT.
  - rx_idle = (counter == TIMEOUT), registered.
  - rx_idle drops the cycle after a push or after the FIFO drains empty.
- uart_ce and uart_rd are registered outputs; no glitching.

Test Plan:
1. Reset with uart_rdc=1 held → no strobe while rst=0. After release, uart_rd/uart_ce are high for exactly 1 cycle, 1 cycle after the IDLE sample. out_valid rises 3 cycles after reset release.
2. Three bytes 0x41, 0x42, 0x43 (error=0,1,0) with out_ready=0 → fifo_count=3. Raising out_ready pops 0x41/err0, 0x42/err1, 0x43/err0 on consecutive cycles. fifo_empty=1 afterwards and out_data=0.
3. Fill with DEPTH=16 bytes 0x00..0x0F while out_ready=0, then hold uart_rdc=1 → fifo_full=1, no further uart_rd. One pop → exactly one new read; count returns to 16.
4. Continuous stream with out_ready=1 and a push/pop in the same cycle → fifo_count stays at 1. Over 40 bytes the output order equals the input order, exercising pointer wrap.
5. uart_rdc held high for 10 cycles for one byte → exactly one uart_rd pulse. A second pulse comes only after uart_rdc goes low and then high again.
6. One byte buffered, out_ready=0, no traffic → rx_idle=1 after 1024 cycles. A new byte clears rx_idle the cycle after CAP. Popping to empty clears rx_idle.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// UART receive buffer: strobes each waiting byte out of the receiver, stores it with its error
// flag in a first-word-fall-through FIFO, and flags an idle timeout while data sits unread.
module uart_rx_fifo #(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned AW      = 4,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    uart_data,
  input  logic          uart_rdc,
  input  logic          uart_error,
  output logic          uart_ce,
  output logic          uart_rd,
  output logic [7:0]    out_data,
  output logic          out_err,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW:0]   fifo_count,
  output logic          fifo_full,
  output logic          fifo_empty,
  output logic          rx_idle
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StRd, StCap, StWait} state_e;

  state_e          state_q, state_d;
  logic            rd_q, rd_d;
  logic [8:0]      mem_q [DEPTH];
  logic [AW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]     count_q, count_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic            idle_q, idle_d;
  logic            push, pop, full, empty;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign push  = (state_q == StCap);
  assign pop   = ~empty & out_ready;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (uart_rdc && !full) state_d = StRd;
      StRd:    state_d = StCap;
      StCap:   state_d = uart_rdc ? StWait : StIdle;
      StWait:  if (!uart_rdc) state_d = StIdle;
      default: state_d = StIdle;
    endcase
    // Strobe is registered so it is high exactly during the RD state.
    rd_d = (state_d == StRd);
  end

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push) wptr_d = wptr_q + 1'b1;
    if (pop)  rptr_d = rptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Timeout counts only while data is buffered and no new byte arrives; saturates at TIMEOUT.
  always_comb begin
    tmo_d = tmo_q;
    if (push || count_d == '0) begin
      tmo_d = '0;
    end else if (tmo_q != TW'(TIMEOUT)) begin
      tmo_d = tmo_q + 1'b1;
    end
    idle_d = (tmo_d == TW'(TIMEOUT));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      rd_q    <= 1'b0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      tmo_q   <= '0;
      idle_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      tmo_q   <= tmo_d;
      idle_q  <= idle_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= {uart_error, uart_data};
  end

  assign uart_ce    = rd_q;
  assign uart_rd    = rd_q;
  assign out_valid  = ~empty;
  assign out_data   = empty ? 8'h00 : mem_q[rptr_q][7:0];
  assign out_err    = empty ? 1'b0  : mem_q[rptr_q][8];
  assign fifo_count = count_q;
  assign fifo_full  = full;
  assign fifo_empty = empty;
  assign rx_idle    = idle_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: a small UART source model feeds bytes, and a scoreboard queue of
// {err, data} is compared against every entry the DUT hands out.
module tb_uart_rx_fifo;

  localparam int unsigned Depth   = 16;
  localparam int unsigned Aw      = 4;
  localparam int unsigned Timeout = 1024;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    uart_data;
  logic          uart_rdc;
  logic          uart_error;
  logic          uart_ce;
  logic          uart_rd;
  logic [7:0]    out_data;
  logic          out_err;
  logic          out_valid;
  logic          out_ready;
  logic [Aw:0]   fifo_count;
  logic          fifo_full;
  logic          fifo_empty;
  logic          rx_idle;

  logic [8:0]    sb [$];
  int            n_checks = 0;
  int            n_pass   = 0;
  int            rd_cnt   = 0;
  int            rd_cnt_rst = 0;
  bit            stream   = 1'b0;

  uart_rx_fifo #(
    .DEPTH   (Depth),
    .AW      (Aw),
    .TIMEOUT (Timeout)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .uart_data  (uart_data),
    .uart_rdc   (uart_rdc),
    .uart_error (uart_error),
    .uart_ce    (uart_ce),
    .uart_rd    (uart_rd),
    .out_data   (out_data),
    .out_err    (out_err),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .fifo_count (fifo_count),
    .fifo_full  (fifo_full),
    .fifo_empty (fifo_empty),
    .rx_idle    (rx_idle)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Inputs change only at posedge+1, so the negedge sees what the next edge will use.
  always @(negedge clk) begin
    logic [8:0] exp;
    if (rst) begin
      if (uart_rd || uart_ce) check_eq("ce_with_rd", 32'(uart_ce), 32'(uart_rd));
      if (uart_rd) rd_cnt++;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check_eq("sb_underflow", 32'(sb.size()), 1);
        end else begin
          exp = sb.pop_front();
          check_eq("pop_entry", 32'({out_err, out_data}), 32'(exp));
        end
      end
    end else if (uart_rd) begin
      rd_cnt_rst++;
    end
  end

  task automatic wait_rd(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (uart_rd) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check_eq("rd_timeout", 0, 1);
  endtask

  // Present a byte, wait for the strobe, keep the data stable through the capture edge.
  task automatic send(input logic [7:0] d, input logic e);
    bit ok;
    uart_data  = d;
    uart_error = e;
    uart_rdc   = 1'b1;
    wait_rd(ok);
    if (ok) sb.push_back({e, d});
    @(posedge clk); #1;
    uart_rdc = 1'b0;
    if (stream) out_ready = 1'b1;
    @(posedge clk); #1;
    if (stream) out_ready = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 64; i++) begin
      @(posedge clk); #1;
      if (fifo_empty) break;
    end
    out_ready = 1'b0;
    check_eq("drain_empty", 32'(fifo_empty), 1);
    check_eq("drain_sb", 32'(sb.size()), 0);
    check_eq("empty_data", 32'({out_err, out_data}), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rd0;
    bit ok;
    rst        = 1'b0;
    uart_rdc   = 1'b1;
    uart_data  = 8'h5A;
    uart_error = 1'b0;
    out_ready  = 1'b0;

    // 1: reset with uart_rdc high
    repeat (5) @(posedge clk);
    #1;
    check_eq("rst_no_strobe", 32'(rd_cnt_rst), 0);
    check_eq("rst_rd_ce", 32'({uart_rd, uart_ce}), 0);
    check_eq("rst_flags", 32'({out_valid, fifo_empty, fifo_full, rx_idle}), 32'b0100);
    check_eq("rst_count", 32'(fifo_count), 0);
    check_eq("rst_out", 32'({out_err, out_data}), 0);
    rst = 1'b1;
    sb.push_back({1'b0, 8'h5A});
    @(posedge clk); #1;
    check_eq("first_rd", 32'({uart_rd, uart_ce}), 32'b11);
    uart_rdc = 1'b0;
    @(posedge clk); #1;
    check_eq("rd_one_cycle", 32'(uart_rd), 0);
    check_eq("valid_not_yet", 32'(out_valid), 0);
    @(posedge clk); #1;
    check_eq("valid_at_3", 32'(out_valid), 1);
    check_eq("first_data", 32'(out_data), 32'h5A);
    drain();

    // 2: three bytes buffered, then popped back to back
    send(8'h41, 1'b0);
    send(8'h42, 1'b1);
    send(8'h43, 1'b0);
    check_eq("count3", 32'(fifo_count), 3);
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    out_ready = 1'b0;
    check_eq("empty_after3", 32'(fifo_empty), 1);
    check_eq("data0_after3", 32'(out_data), 0);

    // 3: fill to full, backpressure, one pop admits exactly one read
    for (int i = 0; i < Depth; i++) send(8'(i), 1'(i % 3 == 0));
    check_eq("full_flag", 32'(fifo_full), 1);
    check_eq("full_count", 32'(fifo_count), Depth);
    rd0 = rd_cnt;
    uart_data = 8'h77;
    uart_error = 1'b1;
    uart_rdc  = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check_eq("no_rd_when_full", rd_cnt - rd0, 0);
    sb.push_back({1'b1, 8'h77});
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    wait_rd(ok);
    @(posedge clk); #1;
    uart_rdc = 1'b0;
    @(posedge clk); #1;
    check_eq("refill_count", 32'(fifo_count), Depth);
    check_eq("one_rd_after_pop", rd_cnt - rd0, 1);
    drain();

    // 4: streaming with push and pop on the same edge; 40 bytes wrap the pointers
    send(8'hA0, 1'b0);
    stream = 1'b1;
    for (int i = 1; i < 40; i++) begin
      send(8'hA0 + 8'(i), 1'(i % 5 == 0));
      check_eq("stream_count", 32'(fifo_count), 1);
    end
    stream = 1'b0;
    drain();

    // 5: uart_rdc held high yields a single read
    rd0 = rd_cnt;
    uart_data  = 8'h55;
    uart_error = 1'b1;
    sb.push_back({1'b1, 8'h55});
    uart_rdc = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check_eq("held_one_rd", rd_cnt - rd0, 1);
    uart_rdc = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    send(8'h66, 1'b0);
    check_eq("second_rd", rd_cnt - rd0, 2);
    drain();

    // 6: idle timeout
    send(8'h99, 1'b0);
    repeat (Timeout - 1) @(posedge clk);
    #1;
    check_eq("idle_not_yet", 32'(rx_idle), 0);
    @(posedge clk); #1;
    check_eq("idle_set", 32'(rx_idle), 1);
    send(8'hAA, 1'b1);
    check_eq("idle_clr_push", 32'(rx_idle), 0);
    repeat (Timeout) @(posedge clk);
    #1;
    check_eq("idle_set2", 32'(rx_idle), 1);
    drain();
    check_eq("idle_clr_drain", 32'(rx_idle), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
